riscv_iter_alu: RTL and testbench

Parametrised multi-cycle integer ALU for the pipelined RISC-V core. It executes every RV32I/RV64I register-register and register-immediate ALU operation, selected by funct3 plus the alternate bit (funct7[5]). ADD/SUB/logic/compare complete in one cycle. Shifts run iteratively at SHIFT_STEP bits per cycle to save area. It sits in EX behind a valid/ready handshake so the hazard unit can stall on busy.

---
 rtl/riscv_iter_alu.sv | 138 +++++++++++++
 tb/tb_riscv_iter_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_iter_alu.sv
// Multi-cycle RV32I/RV64I integer ALU: single-cycle add/sub/logic/compare,
// iterative shifter moving SHIFT_STEP bits per cycle, valid/ready on both sides.
module riscv_iter_alu #(
    parameter int  XLEN       = 32,
    parameter int  SHIFT_STEP = 1,
    localparam int SHAMT_W    = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(SHIFT_STEP);

    state_t              state_reg, state_next;
    logic [XLEN-1:0]     result_reg;
    logic [XLEN-1:0]     work_reg;
    logic [SHAMT_W-1:0]  remaining_reg;
    logic                left_reg;
    logic                arith_reg;

    logic                accept;
    logic                is_shift;
    logic                long_shift;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN-1:0]     alu_value;
    logic [SHAMT_W-1:0]  step;
    logic [SHAMT_W-1:0]  remaining_next;
    logic [XLEN-1:0]     shifted;

    assign in_ready  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg == S_SHIFT);
    assign result    = result_reg;

    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign shamt      = op_b[SHAMT_W-1:0];
    assign long_shift = is_shift && (shamt != '0);

    // Single-cycle datapath; shift codes pass op_a through for the shamt=0 case.
    always_comb begin
        alu_value = '0;
        case (funct3)
            3'b000:  alu_value = alt ? (op_a - op_b) : (op_a + op_b);
            3'b010:  alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011:  alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100:  alu_value = op_a ^ op_b;
            3'b110:  alu_value = op_a | op_b;
            3'b111:  alu_value = op_a & op_b;
            default: alu_value = op_a;
        endcase
    end

    // One shift iteration; the last step may be shorter than SHIFT_STEP.
    always_comb begin
        step           = (remaining_reg >= STEP_C) ? STEP_C : remaining_reg;
        remaining_next = remaining_reg - step;
        if (left_reg)
            shifted = work_reg << step;
        else if (arith_reg)
            shifted = $signed(work_reg) >>> step;
        else
            shifted = work_reg >> step;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept)
                    state_next = long_shift ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                if (remaining_next == '0)
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (accept)
                    state_next = long_shift ? S_SHIFT : S_DONE;
                else if (out_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Result only changes on completion; a flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            work_reg      <= '0;
            remaining_reg <= '0;
            left_reg      <= 1'b0;
            arith_reg     <= 1'b0;
        end else if (flush) begin
            remaining_reg <= '0;
        end else if (accept) begin
            work_reg      <= op_a;
            remaining_reg <= long_shift ? shamt : '0;
            left_reg      <= (funct3 == 3'b001);
            arith_reg     <= alt;
            if (!long_shift)
                result_reg <= alu_value;
        end else if (state_reg == S_SHIFT) begin
            work_reg      <= shifted;
            remaining_reg <= remaining_next;
            if (remaining_next == '0)
                result_reg <= shifted;
        end
    end

endmodule

// File: tb/tb_riscv_iter_alu.sv
// Bench for riscv_iter_alu: vector table plus handshake, flush and reset sequences,
// on a 32-bit/step-1 instance and a 64-bit/step-4 instance.
module tb_riscv_iter_alu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, alt, out_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic        in_ready, out_valid, busy;

    logic        flush_w, in_valid_w, alt_w, out_ready_w;
    logic [2:0]  funct3_w;
    logic [63:0] op_a_w, op_b_w, result_w;
    logic        in_ready_w, out_valid_w, busy_w;

    riscv_iter_alu #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .alt(alt), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    riscv_iter_alu #(.XLEN(64), .SHIFT_STEP(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .funct3(funct3_w), .alt(alt_w), .op_a(op_a_w), .op_b(op_b_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .result(result_w), .busy(busy_w)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[16];
    logic [63:0] sb_q[$];
    int          tests = 0;
    int          fails = 0;

    function automatic vec_t mk(string n, logic [2:0] f, logic al, logic [31:0] a,
                                logic [31:0] b, logic [31:0] e, int l);
        vec_t v;
        v.name = n; v.f3 = f; v.alt = al; v.a = a; v.b = b; v.exp = e; v.lat = l;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run32(vec_t v);
        int lat;
        int bcnt;
        logic [63:0] exp;
        in_valid = 1'b1; funct3 = v.f3; alt = v.alt; op_a = v.a; op_b = v.b; out_ready = 1'b1;
        #1 check({v.name, " in_ready"}, 64'(in_ready), 64'd1);
        sb_q.push_back(64'(v.exp));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        exp = sb_q.pop_front();
        check({v.name, " latency"}, 64'(lat), 64'(v.lat));
        check({v.name, " busy cycles"}, 64'(bcnt), 64'(v.lat - 1));
        check({v.name, " result"}, 64'(result), exp);
        $display("[TB] %s a=%h b=%h -> result=%h latency=%0d", v.name, v.a, v.b, result, lat);
    endtask

    task automatic run64(string name, logic [2:0] f, logic al, logic [63:0] a, logic [63:0] b,
                         logic [63:0] e, int l);
        int lat;
        in_valid_w = 1'b1; funct3_w = f; alt_w = al; op_a_w = a; op_b_w = b; out_ready_w = 1'b1;
        #1 check({name, " in_ready"}, 64'(in_ready_w), 64'd1);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid_w = 1'b0; op_a_w = {$urandom, $urandom};
        lat = 1;
        while (!out_valid_w && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(l));
        check({name, " result"}, result_w, sb_q.pop_front());
        $display("[TB] %s a=%h b=%h -> result=%h latency=%0d", name, a, b, result_w, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prev;
        int seen;

        vecs[0]  = mk("ADD wrap",   3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        vecs[1]  = mk("SUB",        3'b000, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1);
        vecs[2]  = mk("SLT neg",    3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        vecs[3]  = mk("SLTU",       3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        vecs[4]  = mk("SLT pos",    3'b010, 1'b0, 32'h00000005, 32'hFFFFFFFD, 32'h00000000, 1);
        vecs[5]  = mk("ADD ovf",    3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        vecs[6]  = mk("XOR alt",    3'b100, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1);
        vecs[7]  = mk("OR",         3'b110, 1'b0, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1);
        vecs[8]  = mk("AND alt",    3'b111, 1'b1, 32'hFFFF0000, 32'h0FF00FF0, 32'h0FF00000, 1);
        vecs[9]  = mk("SLL alt 4",  3'b001, 1'b1, 32'h00000001, 32'h00000004, 32'h00000010, 5);
        vecs[10] = mk("SRA 31",     3'b101, 1'b1, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32);
        vecs[11] = mk("SRL 31",     3'b101, 1'b0, 32'h80000000, 32'h0000001F, 32'h00000001, 32);
        vecs[12] = mk("SRL shamt0", 3'b101, 1'b0, 32'h80000000, 32'h00000020, 32'h80000000, 1);
        vecs[13] = mk("SRA hi b",   3'b101, 1'b1, 32'h80000000, 32'hFFFFFFE1, 32'hC0000000, 2);
        vecs[14] = mk("SLL 8",      3'b001, 1'b0, 32'hDEADBEEF, 32'h00000008, 32'hADBEEF00, 9);
        vecs[15] = mk("SRA pos",    3'b101, 1'b1, 32'h40000000, 32'h00000002, 32'h10000000, 3);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alt = 1'b0; out_ready = 1'b1;
        funct3 = 3'b000; op_a = '0; op_b = '0;
        flush_w = 1'b0; in_valid_w = 1'b0; alt_w = 1'b0; out_ready_w = 1'b1;
        funct3_w = 3'b000; op_a_w = '0; op_b_w = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset result w", result_w, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run32(vecs[i]);

        // Backpressure: AND result held while out_ready is low.
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; funct3 = 3'b111; alt = 1'b0;
        op_a = 32'hF0F0F0F0; op_b = 32'h0000FFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp result held", 64'(result), 64'h0000F0F0);
            check("bp in_ready low", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        $display("[TB] AND backpressure result=%h", result);
        out_ready = 1'b1; in_valid = 1'b1; funct3 = 3'b100; op_a = 32'h12345678; op_b = 32'h0000FFFF;
        #1 check("bp xor in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp xor no bubble", 64'(out_valid), 64'd1);
        check("bp xor result", 64'(result), 64'h1234A987);
        $display("[TB] XOR back-to-back result=%h", result);
        prev = 32'h1234A987;

        // Flush on the third cycle of a 10-step shift with a request pending.
        in_valid = 1'b1; funct3 = 3'b001; op_a = 32'h1; op_b = 32'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; op_a = 32'h1; op_b = 32'h1;
        #1 check("flush busy before", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush busy", 64'(busy), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush result kept", 64'(result), 64'(prev));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no output", 64'(seen), 64'd0);
        $display("[TB] flush mid-shift, outputs seen=%0d", seen);

        // Asynchronous reset in the middle of a shift.
        in_valid = 1'b1; funct3 = 3'b101; alt = 1'b1; op_a = 32'h80000000; op_b = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        $display("[TB] reset mid-shift busy=%0b out_valid=%0b result=%h", busy, out_valid, result);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run32(mk("ADD after rst", 3'b000, 1'b0, 32'd3, 32'd4, 32'd7, 1));

        run64("W SLL 13", 3'b001, 1'b0, 64'h1, 64'd13, 64'h0000000000002000, 5);
        run64("W SLL 63", 3'b001, 1'b0, 64'h1, 64'd63, 64'h8000000000000000, 17);
        run64("W SRA 6",  3'b101, 1'b1, 64'h8000000000000000, 64'd6, 64'hFE00000000000000, 3);
        run64("W SUB",    3'b000, 1'b1, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
